ysyx_22040632_dc_axi_bridge: RTL and testbench
==============================================

# ysyx_22040632_dc_axi_bridge

Data-side responder for the MEM stage's `mem2dc` request interface. It accepts one load or store at a time, converts it into a single-beat AXI4 read or write transaction, and returns completion plus load data. It sits between the MEM stage and the AXI crossbar, on the uncached path.

## Interface
Parameters:
- AXI_ID, 4'd1: constant ID driven on AWID/ARID.
- ID_W, 4: AXI ID width.

Ports:
- clk  in  1  clock.
- rrst_n  in  1  reset; asynchronous, active-low.
- valid  in  1  MEM request; level, held until the `ready` handshake.
- req  in  1  0 = read (REQ_READ), 1 = write (REQ_WRITE).
- addr  in  32  byte address.
- wmask_uncacheble  in  8  byte strobes, already lane-aligned to addr[2:0].
- data_write  in  64  store data, already lane-shifted.
- ready  out  1  one-cycle completion pulse.
- data_read  out  64  load data, right-aligned by addr[2:0].
- err  out  1  pulses with `ready` when RRESP/BRESP != OKAY.
- awvalid/awready, awaddr[31:0], awid[ID_W], awlen[8], awsize[3], awburst[2]: AXI AW channel.
- wvalid/wready, wdata[64], wstrb[8], wlast: AXI W channel.
- bvalid/bready, bresp[2], bid[ID_W]: AXI B channel.
- arvalid/arready, araddr[31:0], arid[ID_W], arlen[8], arsize[3], arburst[2]: AXI AR channel.
- rvalid/rready, rdata[64], rresp[2], rlast, rid[ID_W]: AXI R channel.

## Operation
- FSM states: IDLE, AR, R, AWW, B, RESP.
- IDLE, valid=1: latch req, addr, wmask_uncacheble and data_write into internal registers. Go to AR if req=0, else AWW. Latched values are used for the rest of the transaction; input changes are ignored.
- AR: arvalid=1, araddr={addr_q[31:3],3'b0}, arsize=3'b011, arlen=0, arburst=INCR(2'b01), arid=AXI_ID. On arready, go to R.
- R: rready=1. On rvalid, capture data_read=rdata>>(addr_q[2:0]*8) with zero fill, set err_q=(rresp!=0), then go to RESP.
- AWW: awvalid and wvalid are both raised on entry, and each drops independently after its own handshake. Write address and size rules match AR. wdata=data_q, wstrb=mask_q, wlast=1. Go to B once both handshakes are done, in either order or in the same cycle.
- B: bready=1. On bvalid, set err_q=(bresp!=0), then go to RESP. data_read is unchanged.
- RESP: ready=1 and err=err_q for exactly one cycle, then unconditionally back to IDLE. MEM drops valid at the same edge, so IDLE never re-accepts the completed request.
- data_read holds its value until the next read completes; writes never alter it.
- rid and bid are ignored: only one transaction is ever outstanding.
- Reset values: FSM=IDLE; all AXI valid/ready outputs 0; ready=0; err=0; data_read=0; latched registers 0.
- Reset mid-transaction: asynchronous return to IDLE with all handshake outputs 0. The in-flight AXI beat is abandoned because the fabric is reset by the same rrst_n.

## Timing
- Read, zero-wait slave: valid sampled in cycle 0 (IDLE); arvalid in cycle 1; R in cycle 2 with rvalid; ready in cycle 3. Minimum latency is 3 cycles.
- Write, zero-wait slave: awvalid and wvalid in cycle 1; B in cycle 2; ready in cycle 3.
- Each stall cycle on arready, rvalid, awready, wready or bvalid adds exactly one cycle.
- Back-to-back requests: the earliest next accept is the cycle after RESP, so the minimum period is 4 cycles per request.
- AXI stability: once asserted, arvalid, awvalid and wvalid and their payloads stay constant until the handshake completes.
- ready is never asserted outside RESP; at most one pulse per accepted request.

## Test plan
- Read: addr=0x8000_0004, req=0, slave returns rdata=0x1122_3344_5566_7788 immediately -> araddr=0x8000_0000, arsize=3, ready pulse in cycle 3, data_read=0x0000_0000_1122_3344, err=0.
- Byte write: addr=0x8000_0003, mask=8'b0000_1000, data_write=0x0000_0000_AB00_0000 -> awaddr=0x8000_0000, wstrb=0x08, wdata unchanged, ready in cycle 3, data_read unchanged.
- Skewed write: wready 3 cycles before awready -> wvalid drops after its handshake, awvalid holds its payload until awready, B entered only after both, a single ready pulse.
- Stalls: arready delayed 2 cycles and rvalid a further 4 -> ready exactly 6 cycles later than the zero-wait case, araddr stable throughout.
- Error: bresp=2'b10 on a write -> ready=1 and err=1 in the same cycle, then both return to 0.
- Reset mid-read: rrst_n low while in R -> rready=0 and ready=0 immediately; after release, a new read completes normally with correct data.

Source files
------------

// File: rtl/ysyx_22040632_dc_axi_bridge_if.sv
// Bundles the MEM-side mem2dc request port and the AXI4 master channels of the data-side bridge.
// The master modport is the bridge's view; the slave modport is the MEM stage plus AXI fabric.
interface ysyx_22040632_dc_axi_bridge_if #(
    parameter int ID_W = 4
);
    logic             valid;
    logic             req;
    logic [31:0]      addr;
    logic [7:0]       wmask_uncacheble;
    logic [63:0]      data_write;
    logic             ready;
    logic [63:0]      data_read;
    logic             err;

    logic             awvalid;
    logic             awready;
    logic [31:0]      awaddr;
    logic [ID_W-1:0]  awid;
    logic [7:0]       awlen;
    logic [2:0]       awsize;
    logic [1:0]       awburst;

    logic             wvalid;
    logic             wready;
    logic [63:0]      wdata;
    logic [7:0]       wstrb;
    logic             wlast;

    logic             bvalid;
    logic             bready;
    logic [1:0]       bresp;
    logic [ID_W-1:0]  bid;

    logic             arvalid;
    logic             arready;
    logic [31:0]      araddr;
    logic [ID_W-1:0]  arid;
    logic [7:0]       arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;

    logic             rvalid;
    logic             rready;
    logic [63:0]      rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic [ID_W-1:0]  rid;

    modport master (
        input  valid, req, addr, wmask_uncacheble, data_write,
        output ready, data_read, err,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        output valid, req, addr, wmask_uncacheble, data_write,
        input  ready, data_read, err,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );
endinterface

// File: rtl/ysyx_22040632_dc_axi_bridge.sv
// Uncached data-side bridge: turns one mem2dc load/store at a time into a single-beat AXI4
// read or write and returns a one-cycle completion pulse with right-aligned load data.
module ysyx_22040632_dc_axi_bridge #(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
    input logic                           clk,
    input logic                           rrst_n,
    ysyx_22040632_dc_axi_bridge_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AWW,
        S_B,
        S_RESP
    } state_t;

    state_t       r_state;
    state_t       w_state_next;

    logic         r_req;
    logic [31:0]  r_addr;
    logic [7:0]   r_mask;
    logic [63:0]  r_data;
    logic [63:0]  r_data_read;
    logic         r_err;
    logic         r_aw_done;
    logic         r_w_done;

    logic         w_aw_hs;
    logic         w_w_hs;
    logic [31:0]  w_axi_addr;
    logic         w_unused;

    assign w_axi_addr = {r_addr[31:3], 3'b000};
    assign w_aw_hs    = bus.awvalid & bus.awready;
    assign w_w_hs     = bus.wvalid & bus.wready;
    // Only one transaction is ever outstanding, so response IDs and rlast carry no information.
    assign w_unused   = ^{bus.rid, bus.bid, bus.rlast};

    assign bus.araddr    = w_axi_addr;
    assign bus.arid      = AXI_ID;
    assign bus.arlen     = 8'd0;
    assign bus.arsize    = 3'b011;
    assign bus.arburst   = 2'b01;
    assign bus.awaddr    = w_axi_addr;
    assign bus.awid      = AXI_ID;
    assign bus.awlen     = 8'd0;
    assign bus.awsize    = 3'b011;
    assign bus.awburst   = 2'b01;
    assign bus.wdata     = r_data;
    assign bus.wstrb     = r_mask;
    assign bus.wlast     = 1'b1;
    assign bus.data_read = r_data_read;

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.arvalid  = 1'b0;
        bus.rready   = 1'b0;
        bus.awvalid  = 1'b0;
        bus.wvalid   = 1'b0;
        bus.bready   = 1'b0;
        bus.ready    = 1'b0;
        bus.err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.valid) begin
                    w_state_next = bus.req ? S_AWW : S_AR;
                end
            end
            S_AR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) begin
                    w_state_next = S_R;
                end
            end
            S_R: begin
                bus.rready = 1'b1;
                if (bus.rvalid) begin
                    w_state_next = S_RESP;
                end
            end
            S_AWW: begin
                // Each valid drops on its own handshake; leave once both have been seen.
                bus.awvalid = ~r_aw_done;
                bus.wvalid  = ~r_w_done;
                if ((r_aw_done | (~r_aw_done & bus.awready)) &&
                    (r_w_done  | (~r_w_done  & bus.wready))) begin
                    w_state_next = S_B;
                end
            end
            S_B: begin
                bus.bready = 1'b1;
                if (bus.bvalid) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.ready    = 1'b1;
                bus.err      = r_err;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_req       <= 1'b0;
            r_addr      <= 32'd0;
            r_mask      <= 8'd0;
            r_data      <= 64'd0;
            r_data_read <= 64'd0;
            r_err       <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid) begin
                        r_req     <= bus.req;
                        r_addr    <= bus.addr;
                        r_mask    <= bus.wmask_uncacheble;
                        r_data    <= bus.data_write;
                        r_err     <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                S_R: begin
                    if (bus.rvalid && !r_req) begin
                        r_data_read <= bus.rdata >> {r_addr[2:0], 3'b000};
                        r_err       <= (bus.rresp != 2'b00);
                    end
                end
                S_AWW: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                end
                S_B: begin
                    if (bus.bvalid) begin
                        r_err <= (bus.bresp != 2'b00);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040632_dc_axi_bridge.sv
// Directed bench for the data-side AXI bridge: a cycle-stepped AXI slave with per-channel
// stall counts and a scoreboard of expected completions checked when ready pulses.
module tb_ysyx_22040632_dc_axi_bridge;
    logic clk = 1'b0;
    logic rrst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22040632_dc_axi_bridge_if #(.ID_W(4)) bus ();

    ysyx_22040632_dc_axi_bridge #(.ID_W(4), .AXI_ID(4'd1)) dut (
        .clk    (clk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [63:0] dr;
        logic        er;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model_dr = 64'd0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 64'd0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
        bus.rid     = 4'd0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        bus.bid     = 4'd0;
    endtask

    // Called at posedge+#1 with the DUT idle. d_a: AR/AW stall, d_d: R/W stall, d_b: B stall.
    task automatic txn(input logic wr, input logic [31:0] a, input logic [7:0] m,
                       input logic [63:0] wd, input logic [63:0] rd, input logic [1:0] resp,
                       input int d_a, input int d_d, input int d_b);
        exp_t        e;
        int          cyc;
        int          a_seen, d_seen, b_seen;
        bit          a_done, d_done, b_done, got;
        bit          aw_fire, w_fire;
        logic [31:0] exp_ax;
        exp_ax = {a[31:3], 3'b000};
        e.er   = (resp != 2'b00);
        if (wr) begin
            e.dr  = model_dr;
            e.cyc = 3 + ((d_a > d_d) ? d_a : d_d) + d_b;
        end else begin
            e.dr     = rd >> {a[2:0], 3'b000};
            e.cyc    = 3 + d_a + d_d;
            model_dr = e.dr;
        end
        sb.push_back(e);
        bus.valid = 1'b1;
        bus.req = wr;
        bus.addr = a;
        bus.wmask_uncacheble = m;
        bus.data_write = wd;
        cyc = 0; a_seen = 0; d_seen = 0; b_seen = 0;
        a_done = 0; d_done = 0; b_done = 0; got = 0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            slave_idle();
            if (bus.ready) begin
                got = 1;
                if (sb.size() == 0) begin
                    chk("ready_spurious", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("data_read", bus.data_read, e.dr);
                    chk("err", {63'd0, bus.err}, {63'd0, e.er});
                    chk("latency", 64'(cyc), 64'(e.cyc));
                end
                $display("[TB] txn %s addr=%h data_read=%h err=%b cycles=%0d",
                         wr ? "write" : "read ", a, bus.data_read, bus.err, cyc);
            end else if (cyc == 0) begin
                chk("idle_quiet", {61'd0, bus.arvalid, bus.awvalid, bus.wvalid}, 64'd0);
            end else if (!wr) begin
                if (!a_done) begin
                    chk("arvalid", {63'd0, bus.arvalid}, 64'd1);
                    chk("araddr", {32'd0, bus.araddr}, {32'd0, exp_ax});
                    chk("ar_attr", {46'd0, bus.arsize, bus.arlen, bus.arburst, bus.arid},
                        {46'd0, 3'b011, 8'd0, 2'b01, 4'd1});
                    bus.arready = (a_seen >= d_a);
                    a_done = bus.arready;
                    a_seen++;
                end else if (!d_done) begin
                    chk("rready", {63'd0, bus.rready}, 64'd1);
                    if (d_seen >= d_d) begin
                        bus.rvalid = 1'b1;
                        bus.rdata  = rd;
                        bus.rresp  = resp;
                        bus.rlast  = 1'b1;
                        bus.rid    = 4'd1;
                        d_done     = 1;
                    end
                    d_seen++;
                end
            end else begin
                if (!(a_done && d_done)) begin
                    chk("awvalid", {63'd0, bus.awvalid}, {63'd0, !a_done});
                    chk("wvalid", {63'd0, bus.wvalid}, {63'd0, !d_done});
                    aw_fire = 0;
                    w_fire = 0;
                    if (!a_done) begin
                        chk("awaddr", {32'd0, bus.awaddr}, {32'd0, exp_ax});
                        chk("aw_attr", {46'd0, bus.awsize, bus.awlen, bus.awburst, bus.awid},
                            {46'd0, 3'b011, 8'd0, 2'b01, 4'd1});
                        aw_fire = (a_seen >= d_a);
                        a_seen++;
                    end
                    if (!d_done) begin
                        chk("wdata", bus.wdata, wd);
                        chk("wstrb_wlast", {55'd0, bus.wstrb, bus.wlast}, {55'd0, m, 1'b1});
                        w_fire = (d_seen >= d_d);
                        d_seen++;
                    end
                    bus.awready = aw_fire;
                    bus.wready  = w_fire;
                    a_done = a_done | aw_fire;
                    d_done = d_done | w_fire;
                end else if (!b_done) begin
                    chk("bready", {63'd0, bus.bready}, 64'd1);
                    if (b_seen >= d_b) begin
                        bus.bvalid = 1'b1;
                        bus.bresp  = resp;
                        bus.bid    = 4'd1;
                        b_done     = 1;
                    end
                    b_seen++;
                end
            end
            if (!got) begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc == 1) begin
                    // Request payload changes after acceptance must not reach the bus.
                    bus.req = ~wr;
                    bus.addr = ~a;
                    bus.wmask_uncacheble = ~m;
                    bus.data_write = ~wd;
                end
            end
        end
        if (!got) begin
            chk("timeout", 64'd0, 64'd1);
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        slave_idle();
        chk("ready_drop", {62'd0, bus.ready, bus.err}, 64'd0);
        bus.valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid = 1'b0;
        bus.req = 1'b0;
        bus.addr = 32'd0;
        bus.wmask_uncacheble = 8'd0;
        bus.data_write = 64'd0;
        slave_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_handshake", {58'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                              bus.bready, bus.ready}, 64'd0);
        chk("rst_err", {63'd0, bus.err}, 64'd0);
        chk("rst_data_read", bus.data_read, 64'd0);
        #2 rrst_n = 1'b1;
        @(posedge clk);
        #1;

        txn(1'b0, 32'h8000_0004, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0);
        txn(1'b1, 32'h8000_0003, 8'h08, 64'h0000_0000_AB00_0000, 64'd0, 2'b00, 0, 0, 0);
        txn(1'b1, 32'h8000_0020, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'd0, 2'b00, 3, 0, 0);
        txn(1'b1, 32'h8000_0028, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0, 2'b00, 0, 2, 1);
        txn(1'b0, 32'h8000_0107, 8'h00, 64'd0, 64'hA1B2_C3D4_E5F6_0718, 2'b00, 2, 4, 0);
        txn(1'b1, 32'h8000_0040, 8'h0F, 64'h0000_0000_CAFE_F00D, 64'd0, 2'b10, 0, 0, 2);
        txn(1'b0, 32'h8000_0200, 8'h00, 64'd0, 64'hFEDC_BA98_7654_3210, 2'b11, 1, 1, 0);
        txn(1'b1, 32'h8000_0208, 8'h01, 64'h0000_0000_0000_0055, 64'd0, 2'b00, 2, 2, 0);

        // Reset while waiting in R for data.
        bus.valid = 1'b1;
        bus.req = 1'b0;
        bus.addr = 32'h8000_0010;
        @(negedge clk);
        bus.arready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_arvalid", {63'd0, bus.arvalid}, 64'd1);
        bus.arready = 1'b1;
        @(posedge clk);
        #1;
        bus.arready = 1'b0;
        chk("mid_rready", {63'd0, bus.rready}, 64'd1);
        #1 rrst_n = 1'b0;
        #1;
        chk("mid_rst_hs", {59'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.ready},
            64'd0);
        chk("mid_rst_data", bus.data_read, 64'd0);
        bus.valid = 1'b0;
        model_dr = 64'd0;
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rrst_n = 1'b1;
        @(posedge clk);
        #1;
        txn(1'b0, 32'h8000_0012, 8'h00, 64'd0, 64'h0011_2233_4455_6677, 2'b00, 0, 1, 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
